// File: rtl/wb_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : wb_snoop_responder
// Purpose  : Per-core coherence snoop responder with a shadow dcache directory.
// Revision : 1.0 - initial release
// ============================================================================
module wb_snoop_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SET_WIDTH   = 8,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] snoop_adr_i,
    input  logic                  snoop_req_i,
    output logic                  snoop_ack_o,
    output logic                  snoop_hit_o,
    output logic [DATA_WIDTH-1:0] snoop_dat_o,
    input  logic                  dir_we_i,
    input  logic [ADDR_WIDTH-1:0] dir_adr_i,
    input  logic                  dir_valid_i,
    input  logic                  dir_dirty_i,
    output logic                  dir_stall_o,
    output logic                  cache_rd_req_o,
    output logic [ADDR_WIDTH-1:0] cache_rd_adr_o,
    input  logic                  cache_rd_ack_i,
    input  logic [DATA_WIDTH-1:0] cache_rd_dat_i,
    output logic                  cache_inval_o,
    output logic [ADDR_WIDTH-1:0] cache_inval_adr_o
);
    localparam int C_TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - BLOCK_WIDTH;
    localparam int C_NUM_SETS  = 1 << SET_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_READ      = 3'd2,
        S_RESP      = 3'd3,
        S_WAIT_DROP = 3'd4
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_adr, w_adr_nxt;
    logic                    r_ack, w_ack_nxt;
    logic                    r_hit, w_hit_nxt;
    logic [DATA_WIDTH-1:0]   r_dat, w_dat_nxt;
    logic                    r_stall, w_stall_nxt;
    logic                    r_rd_req, w_rd_req_nxt;
    logic [ADDR_WIDTH-1:0]   r_rd_adr, w_rd_adr_nxt;
    logic                    r_inval, w_inval_nxt;
    logic [ADDR_WIDTH-1:0]   r_inval_adr, w_inval_adr_nxt;

    logic [C_NUM_SETS-1:0]   r_valid;
    logic [C_NUM_SETS-1:0]   r_dirty;
    logic [C_TAG_WIDTH-1:0]  r_tag [C_NUM_SETS];

    logic [SET_WIDTH-1:0]    w_snp_idx, w_dir_idx;
    logic [C_TAG_WIDTH-1:0]  w_snp_tag, w_dir_tag;
    logic [ADDR_WIDTH-1:0]   w_line_adr, w_word_adr;
    logic                    w_lookup_hit, w_dir_wr, w_clr_valid, w_clr_dirty;
    logic                    w_unused;

    assign w_snp_idx    = r_adr[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
    assign w_snp_tag    = r_adr[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH];
    assign w_dir_idx    = dir_adr_i[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
    assign w_dir_tag    = dir_adr_i[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH];
    assign w_line_adr   = {r_adr[ADDR_WIDTH-1:BLOCK_WIDTH], {BLOCK_WIDTH{1'b0}}};
    assign w_word_adr   = {r_adr[ADDR_WIDTH-1:2], 2'b00};
    assign w_lookup_hit = r_valid[w_snp_idx] && (r_tag[w_snp_idx] == w_snp_tag);
    // The cache holds its write while stalled, so it is simply not taken here.
    assign w_dir_wr     = dir_we_i && !r_stall;
    assign w_unused     = &{1'b0, r_adr[1:0], dir_adr_i[BLOCK_WIDTH-1:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_adr_nxt       = r_adr;
        w_ack_nxt       = 1'b0;
        w_hit_nxt       = 1'b0;
        w_dat_nxt       = '0;
        w_rd_req_nxt    = r_rd_req;
        w_rd_adr_nxt    = r_rd_adr;
        w_inval_nxt     = 1'b0;
        w_inval_adr_nxt = r_inval_adr;
        w_clr_valid     = 1'b0;
        w_clr_dirty     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (snoop_req_i) begin
                    w_adr_nxt   = snoop_adr_i;
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!w_lookup_hit) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (!r_dirty[w_snp_idx]) begin
                    w_clr_valid     = 1'b1;
                    w_inval_nxt     = 1'b1;
                    w_inval_adr_nxt = w_line_adr;
                    w_ack_nxt       = 1'b1;
                    w_hit_nxt       = 1'b1;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_rd_req_nxt = 1'b1;
                    w_rd_adr_nxt = w_word_adr;
                    w_state_nxt  = S_READ;
                end
            end
            S_READ: begin
                if (cache_rd_ack_i) begin
                    w_dat_nxt       = cache_rd_dat_i;
                    w_clr_valid     = 1'b1;
                    w_clr_dirty     = 1'b1;
                    w_inval_nxt     = 1'b1;
                    w_inval_adr_nxt = w_line_adr;
                    w_rd_req_nxt    = 1'b0;
                    w_ack_nxt       = 1'b1;
                    w_hit_nxt       = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!snoop_req_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_stall_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_adr       <= '0;
            r_ack       <= 1'b0;
            r_hit       <= 1'b0;
            r_dat       <= '0;
            r_stall     <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_adr    <= '0;
            r_inval     <= 1'b0;
            r_inval_adr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_adr       <= w_adr_nxt;
            r_ack       <= w_ack_nxt;
            r_hit       <= w_hit_nxt;
            r_dat       <= w_dat_nxt;
            r_stall     <= w_stall_nxt;
            r_rd_req    <= w_rd_req_nxt;
            r_rd_adr    <= w_rd_adr_nxt;
            r_inval     <= w_inval_nxt;
            r_inval_adr <= w_inval_adr_nxt;
        end
    end

    // Cache writes and snoop invalidates never coincide: the latter only occur while stalled.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_dir_wr) begin
                r_valid[w_dir_idx] <= dir_valid_i;
                r_dirty[w_dir_idx] <= dir_dirty_i;
            end
            if (w_clr_valid) begin
                r_valid[w_snp_idx] <= 1'b0;
            end
            if (w_clr_dirty) begin
                r_dirty[w_snp_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_dir_wr) begin
            r_tag[w_dir_idx] <= w_dir_tag;
        end
    end

    assign snoop_ack_o       = r_ack;
    assign snoop_hit_o       = r_hit;
    assign snoop_dat_o       = r_dat;
    assign dir_stall_o       = r_stall;
    assign cache_rd_req_o    = r_rd_req;
    assign cache_rd_adr_o    = r_rd_adr;
    assign cache_inval_o     = r_inval;
    assign cache_inval_adr_o = r_inval_adr;

endmodule
`default_nettype wire

// File: tb/tb_wb_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_snoop_responder
// Purpose  : Directed scoreboard bench for wb_snoop_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_snoop_responder;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk, rst;
    logic [AW-1:0] snoop_adr;
    logic          snoop_req, snoop_ack, snoop_hit;
    logic [DW-1:0] snoop_dat;
    logic          dir_we, dir_valid, dir_dirty, dir_stall;
    logic [AW-1:0] dir_adr;
    logic          cache_rd_req, cache_rd_ack, cache_inval;
    logic [AW-1:0] cache_rd_adr, cache_inval_adr;
    logic [DW-1:0] cache_rd_dat;
    logic [100:0]  w_outs;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            ack_cnt = 0;
    int            stall_cnt = 0;
    int            inval_cnt = 0;
    logic [AW-1:0] last_inval_adr = '0;
    logic [AW-1:0] rd_adr_seen = '0;
    logic          cache_en;
    logic [DW-1:0] cache_word;

    wb_snoop_responder dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .snoop_adr_i       (snoop_adr),
        .snoop_req_i       (snoop_req),
        .snoop_ack_o       (snoop_ack),
        .snoop_hit_o       (snoop_hit),
        .snoop_dat_o       (snoop_dat),
        .dir_we_i          (dir_we),
        .dir_adr_i         (dir_adr),
        .dir_valid_i       (dir_valid),
        .dir_dirty_i       (dir_dirty),
        .dir_stall_o       (dir_stall),
        .cache_rd_req_o    (cache_rd_req),
        .cache_rd_adr_o    (cache_rd_adr),
        .cache_rd_ack_i    (cache_rd_ack),
        .cache_rd_dat_i    (cache_rd_dat),
        .cache_inval_o     (cache_inval),
        .cache_inval_adr_o (cache_inval_adr)
    );

    assign w_outs = {snoop_ack, snoop_hit, snoop_dat, cache_rd_req, cache_rd_adr,
                     cache_inval, cache_inval_adr, dir_stall};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and tracks side-band activity.
    always @(negedge clk) begin
        if (!rst) begin
            if (dir_stall) stall_cnt++;
            if (cache_inval) begin
                inval_cnt++;
                last_inval_adr = cache_inval_adr;
            end
            if (snoop_ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 128'(1), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("snoop_resp", 128'({snoop_hit, snoop_dat}), 128'(mon_e));
                end
            end else if (snoop_hit || snoop_dat != '0) begin
                check("resp_zero_without_ack", 128'({snoop_hit, snoop_dat}), 128'(0));
            end
        end
    end

    // Cache data RAM model: acks a read three cycles after noticing it.
    initial begin
        cache_rd_ack = 1'b0;
        cache_rd_dat = '0;
        forever begin
            @(negedge clk);
            if (cache_rd_req && cache_en && !rst) begin
                rd_adr_seen = cache_rd_adr;
                repeat (3) @(posedge clk);
                #1;
                cache_rd_ack = 1'b1;
                cache_rd_dat = cache_word;
                @(posedge clk);
                #1;
                cache_rd_ack = 1'b0;
                cache_rd_dat = '0;
            end
        end
    end

    task automatic dir_write(input logic [AW-1:0] a, input logic v, input logic d);
        @(posedge clk); #1;
        dir_we = 1'b1; dir_adr = a; dir_valid = v; dir_dirty = d;
        @(posedge clk); #1;
        dir_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dir_stall && n < 40);
        if (dir_stall) check("idle_timeout", 128'(1), 128'(0));
    endtask

    // wmode: 0 none, 1 dir write with the request, 2 write pulsed while stalled,
    // 3 write raised while stalled and held until accepted.
    task automatic snoop(input logic [AW-1:0] adr, input logic exp_hit, input logic [DW-1:0] exp_dat,
                         input int exp_lat, input int wmode, input logic [AW-1:0] wadr,
                         input logic wdirty, input int hold);
        int   n;
        int   acks0;
        bit   seen;
        exp_t e;
        e.hit = exp_hit;
        e.dat = exp_dat;
        exp_q.push_back(e);
        acks0     = ack_cnt;
        stall_cnt = 0;
        seen      = 1'b0;
        n         = 0;
        @(posedge clk); #1;
        snoop_adr = adr;
        snoop_req = 1'b1;
        if (wmode == 1) begin
            dir_we = 1'b1; dir_adr = wadr; dir_valid = 1'b1; dir_dirty = wdirty;
        end
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                snoop_adr = 32'hFFFF_FFF0;
                dir_we    = (wmode >= 2);
                dir_adr   = wadr; dir_valid = 1'b1; dir_dirty = wdirty;
            end
            if (n == 3 && wmode == 2) dir_we = 1'b0;
            seen = snoop_ack;
        end
        if (seen) check("ack_latency", 128'(n), 128'(exp_lat));
        else      check("ack_timeout", 128'(0), 128'(1));
        repeat (1 + hold) @(posedge clk);
        #1;
        snoop_req = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        dir_we = 1'b0;
        check("ack_once", 128'(ack_cnt - acks0), 128'(1));
    endtask

    initial begin
        int   n;
        int   acks0;
        bit   seen;
        exp_t e;
        rst = 1'b1; snoop_req = 1'b0; snoop_adr = '0;
        dir_we = 1'b0; dir_adr = '0; dir_valid = 1'b0; dir_dirty = 1'b0;
        cache_en = 1'b1; cache_word = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(w_outs), 128'(0));
        rst = 1'b0;

        // Empty directory: plain miss.
        snoop(32'h0000_1230, 1'b0, '0, 3, 0, '0, 1'b0, 0);
        check("miss_stall_cycles", 128'(stall_cnt), 128'(3));
        check("miss_no_inval", 128'(inval_cnt), 128'(0));

        // Clean hit, then a held request that must not be re-answered.
        dir_write(32'h0000_1230, 1'b1, 1'b0);
        snoop(32'h0000_1234, 1'b1, '0, 3, 0, '0, 1'b0, 0);
        check("clean_inval_count", 128'(inval_cnt), 128'(1));
        check("clean_inval_adr", 128'(last_inval_adr), 128'(32'h0000_1230));
        snoop(32'h0000_1234, 1'b0, '0, 3, 0, '0, 1'b0, 4);
        check("repeat_no_inval", 128'(inval_cnt), 128'(1));

        // Dirty hit with a read-back.
        dir_write(32'h0000_2240, 1'b1, 1'b1);
        cache_word = 32'hDEAD_BEEF;
        snoop(32'h0000_2248, 1'b1, 32'hDEAD_BEEF, 7, 0, '0, 1'b0, 0);
        check("dirty_rd_adr", 128'(rd_adr_seen), 128'(32'h0000_2248));
        check("dirty_inval_count", 128'(inval_cnt), 128'(2));
        check("dirty_inval_adr", 128'(last_inval_adr), 128'(32'h0000_2240));
        snoop(32'h0000_2248, 1'b0, '0, 3, 0, '0, 1'b0, 0);

        // Same set, different tag: miss and the entry survives.
        dir_write(32'h0000_1230, 1'b1, 1'b0);
        snoop(32'h0001_1230, 1'b0, '0, 3, 0, '0, 1'b0, 0);
        check("tag_miss_no_inval", 128'(inval_cnt), 128'(2));
        snoop(32'h0000_1230, 1'b1, '0, 3, 0, '0, 1'b0, 0);
        check("tag_entry_kept", 128'(inval_cnt), 128'(3));

        // Directory write in the same cycle as the request.
        snoop(32'h0000_3350, 1'b1, '0, 3, 1, 32'h0000_3350, 1'b0, 0);

        // Writes while stalled: dropped if released early, taken if held.
        snoop(32'h0000_4460, 1'b0, '0, 3, 2, 32'h0000_5570, 1'b0, 0);
        snoop(32'h0000_5570, 1'b0, '0, 3, 0, '0, 1'b0, 0);
        snoop(32'h0000_4460, 1'b0, '0, 3, 3, 32'h0000_5570, 1'b1, 0);
        cache_word = 32'h1234_5678;
        snoop(32'h0000_5574, 1'b1, 32'h1234_5678, 7, 0, '0, 1'b0, 0);
        check("held_write_rd_adr", 128'(rd_adr_seen), 128'(32'h0000_5574));

        // Reset in the middle of a dirty read.
        dir_write(32'h0000_1230, 1'b1, 1'b0);
        dir_write(32'h0000_2240, 1'b1, 1'b1);
        cache_en = 1'b0;
        @(posedge clk); #1;
        snoop_adr = 32'h0000_2248;
        snoop_req = 1'b1;
        n = 0;
        while (!cache_rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("read_reached", 128'(cache_rd_req), 128'(1));
        acks0 = ack_cnt;
        #2 rst = 1'b1;
        #1 check("reset_mid_read_outputs", 128'(w_outs), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        check("no_ack_on_reset", 128'(ack_cnt - acks0), 128'(0));
        e.hit = 1'b0;
        e.dat = '0;
        exp_q.push_back(e);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = snoop_ack;
        end
        check("post_reset_latency", 128'(n), 128'(2));
        @(posedge clk); #1;
        snoop_req = 1'b0;
        wait_idle();
        cache_en = 1'b1;
        snoop(32'h0000_1230, 1'b0, '0, 3, 0, '0, 1'b0, 0);

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
